// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one MIPS instruction, drives the ALU for one cycle, returns result.
// Optional ALU_ISSUE_SIGNED_SLT_EN: flip operand MSBs on slt/slti for a signed compare.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [3:0]  NOP_CTRL = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_taken,
  output logic              rsp_illegal
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
  typedef enum logic [1:0] {BrNone, BrEq, BrNe} br_e;

  state_e              state_q;
  br_e                 br_q, dec_br;
  logic                ill_q, dec_ill;
  logic [3:0]          ctrl_q, dec_ctrl;
  logic [DATA_W-1:0]   data1_q, data2_q, dec_d2, slt_flip;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_zero_q, rsp_taken_q, rsp_illegal_q;
  logic [DATA_W-1:0]   imm_sext, imm_zext;

  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  always_comb begin
    dec_ctrl = NOP_CTRL;
    dec_d2   = rt_val;
    dec_br   = BrNone;
    dec_ill  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: dec_ctrl = 4'b0010;
          6'h22, 6'h23: dec_ctrl = 4'b0110;
          6'h24:        dec_ctrl = 4'b0000;
          6'h25:        dec_ctrl = 4'b0001;
          6'h26:        dec_ctrl = 4'b1100;
          6'h2A:        dec_ctrl = 4'b0111;
          6'h00:        dec_ctrl = NOP_CTRL;
          default:      dec_ill  = 1'b1;
        endcase
      end
      6'h08, 6'h23, 6'h2B: begin dec_ctrl = 4'b0010; dec_d2 = imm_sext; end
      6'h0A:               begin dec_ctrl = 4'b0111; dec_d2 = imm_sext; end
      6'h0C:               begin dec_ctrl = 4'b0000; dec_d2 = imm_zext; end
      6'h0D:               begin dec_ctrl = 4'b0001; dec_d2 = imm_zext; end
      6'h0E:               begin dec_ctrl = 4'b1100; dec_d2 = imm_zext; end
      6'h04:               begin dec_ctrl = 4'b0110; dec_br = BrEq; end
      6'h05:               begin dec_ctrl = 4'b0110; dec_br = BrNe; end
      default:             dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_SIGNED_SLT_EN
  // Biasing both MSBs turns the ALU's unsigned compare into a signed one.
  assign slt_flip = (dec_ctrl == 4'b0111) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
`else
  assign slt_flip = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ctrl_q        <= NOP_CTRL;
      data1_q       <= '0;
      data2_q       <= '0;
      br_q          <= BrNone;
      ill_q         <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            ctrl_q  <= dec_ill ? NOP_CTRL : dec_ctrl;
            data1_q <= rs_val ^ slt_flip;
            data2_q <= dec_d2 ^ slt_flip;
            br_q    <= dec_br;
            ill_q   <= dec_ill;
            state_q <= StExec;
          end
        end
        StExec: begin
          ctrl_q  <= NOP_CTRL;
          state_q <= StResp;
          if (ill_q) begin
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b1;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b1;
          end else begin
            rsp_result_q  <= alu_result;
            rsp_zero_q    <= alu_zero;
            rsp_illegal_q <= 1'b0;
            case (br_q)
              BrEq:    rsp_taken_q <= alu_zero;
              BrNe:    rsp_taken_q <= ~alu_zero;
              default: rsp_taken_q <= 1'b0;
            endcase
          end
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign alu_ctrl    = ctrl_q;
  assign alu_data1   = data1_q;
  assign alu_data2   = data2_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_taken   = rsp_taken_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit-ctrl ALU attached.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_taken, rsp_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .NOP_CTRL(4'b1111)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .opcode      (opcode),
    .funct       (funct),
    .imm         (imm),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_taken   (rsp_taken),
    .rsp_illegal (rsp_illegal)
  );

  // Reference ALU: 0111 is an unsigned set-less-than.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0111: alu_result = (alu_data1 < alu_data2) ? 32'd1 : 32'd0;
      4'b1100: alu_result = alu_data1 ^ alu_data2;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [3:0] e_ctrl, input logic chk_data,
                        input logic [31:0] e_d1, input logic [31:0] e_d2,
                        input logic [31:0] e_res, input logic e_zero, input logic e_taken,
                        input logic e_ill);
    check({tag, ":idle_ready"}, 32'(req_ready), 32'd1);
    opcode = op; funct = fn; imm = im; rs_val = rs; rt_val = rt;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, ":exec_ctrl"}, 32'(alu_ctrl), 32'(e_ctrl));
    if (chk_data) begin
      check({tag, ":exec_d1"}, alu_data1, e_d1);
      check({tag, ":exec_d2"}, alu_data2, e_d2);
    end
    check({tag, ":exec_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":exec_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, ":resp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ":resp_ctrl"}, 32'(alu_ctrl), 32'hF);
    check({tag, ":result"}, rsp_result, e_res);
    check({tag, ":zero"}, 32'(rsp_zero), 32'(e_zero));
    check({tag, ":taken"}, 32'(rsp_taken), 32'(e_taken));
    check({tag, ":illegal"}, 32'(rsp_illegal), 32'(e_ill));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ":done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ":done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = '0; funct = '0; imm = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst:valid", 32'(rsp_valid), 32'd0);
    check("rst:ready", 32'(req_ready), 32'd1);
    check("rst:ctrl", 32'(alu_ctrl), 32'hF);
    check("rst:d1", alu_data1, 32'd0);
    check("rst:d2", alu_data2, 32'd0);
    check("rst:result", rsp_result, 32'd0);
    check("rst:zero", 32'(rsp_zero), 32'd0);

    run_op("add", 6'h00, 6'h20, 16'h0, 32'd5, 32'd7, 4'b0010, 1'b1,
           32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    run_op("beq", 6'h04, 6'h00, 16'h0, 32'h1234, 32'h1234, 4'b0110, 1'b1,
           32'h1234, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
    run_op("bne", 6'h05, 6'h00, 16'h0, 32'h1234, 32'h1234, 4'b0110, 1'b1,
           32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_ISSUE_SIGNED_SLT_EN
    run_op("slti", 6'h0A, 6'h00, 16'h0001, 32'hFFFF_FFFF, 32'd0, 4'b0111, 1'b1,
           32'h7FFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 1'b0);
`else
    run_op("slti", 6'h0A, 6'h00, 16'h0001, 32'hFFFF_FFFF, 32'd0, 4'b0111, 1'b1,
           32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1'b1, 1'b0, 1'b0);
`endif
    run_op("ori", 6'h0D, 6'h00, 16'h8001, 32'hF000_0000, 32'd0, 4'b0001, 1'b1,
           32'hF000_0000, 32'h0000_8001, 32'hF000_8001, 1'b0, 1'b0, 1'b0);
    run_op("addi", 6'h08, 6'h00, 16'hFFFF, 32'd5, 32'd0, 4'b0010, 1'b1,
           32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0, 1'b0);
    run_op("xor", 6'h00, 6'h26, 16'h0, 32'h0000_FF00, 32'h0000_0FF0, 4'b1100, 1'b1,
           32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, 1'b0, 1'b0, 1'b0);
    run_op("illegal", 6'h3F, 6'h00, 16'h0, 32'h11, 32'h22, 4'b1111, 1'b0,
           32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure: sub 9-9 held in RESP for 5 cycles.
    opcode = 6'h00; funct = 6'h22; rs_val = 32'd9; rt_val = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp:valid", 32'(rsp_valid), 32'd1);
      check("bp:ready", 32'(req_ready), 32'd0);
      check("bp:result", rsp_result, 32'd0);
      check("bp:zero", 32'(rsp_zero), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1 check("bp:ready_in_resp", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp:idle_valid", 32'(rsp_valid), 32'd0);
    run_op("bp_next", 6'h00, 6'h24, 16'h0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0000, 1'b1,
           32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);

    // Reset while in EXEC discards the request.
    opcode = 6'h00; funct = 6'h20; rs_val = 32'd1; rt_val = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstx:in_exec", 32'(alu_ctrl), 32'b0010);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstx:valid", 32'(rsp_valid), 32'd0);
    check("rstx:ctrl", 32'(alu_ctrl), 32'hF);
    check("rstx:ready", 32'(req_ready), 32'd1);
    check("rstx:d1", alu_data1, 32'd0);
    check("rstx:result", rsp_result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstx:no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
